// File: rtl/pipe_stage_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs_pkg
// Purpose  : Shared definitions for the handshaked pipeline stage registers.
//            - Field widths and bit offsets of the E/M stage payload. The
//              offsets are chained, so the total width follows automatically.
//            - Skid-buffer occupancy state encoding.
//            - Bubble (nop) fill value. A bubble is an all-zero payload.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_hs_pkg;

  // E/M payload layout, LSB first: A3, RD2, ALUOut, PC+8, PC, Instr
  localparam int EM_A3_W     = 5;
  localparam int EM_RD2_W    = 32;
  localparam int EM_ALUOUT_W = 32;
  localparam int EM_PC8_W    = 32;
  localparam int EM_PC_W     = 32;
  localparam int EM_INSTR_W  = 32;

  localparam int EM_A3_LSB     = 0;
  localparam int EM_RD2_LSB    = EM_A3_LSB     + EM_A3_W;
  localparam int EM_ALUOUT_LSB = EM_RD2_LSB    + EM_RD2_W;
  localparam int EM_PC8_LSB    = EM_ALUOUT_LSB + EM_ALUOUT_W;
  localparam int EM_PC_LSB     = EM_PC8_LSB    + EM_PC8_W;
  localparam int EM_INSTR_LSB  = EM_PC_LSB     + EM_PC_W;

  // 165 bits for the default E/M stage
  localparam int EM_PAYLOAD_W  = EM_INSTR_LSB  + EM_INSTR_W;

  // Every payload bit of a bubble takes this value (all-zero nop)
  localparam logic BUBBLE_FILL = 1'b0;

  // Entries held by a skid-buffered stage; the encoding equals the count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage : pipe_stage_hs_pkg
`default_nettype wire

// File: rtl/pipe_stage_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs_if
// Purpose  : One valid/ready handshake channel carrying a packed payload.
// Ports    : none; signals valid, ready, data[W-1:0]
//            modport master : producer (drives valid/data, sees ready)
//            modport slave  : consumer (sees valid/data, drives ready)
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_hs_if
  import pipe_stage_hs_pkg::*;
#(
  parameter int W = EM_PAYLOAD_W
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface : pipe_stage_hs_if
`default_nettype wire

// File: rtl/pipe_stage_hs_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs_slot
// Purpose  : One storage entry of a pipeline stage. It holds a payload
//            register and a valid bit.
//            Priority: clear > load > drop.
//              clear : valid <= 0, payload <= bubble if CLEAR_DATA
//              load  : payload <= d, valid <= 1
//              drop  : valid <= 0, payload kept
// Ports    : clk, reset (async, active-low), load, drop, clear, d, q, valid
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs_slot
  import pipe_stage_hs_pkg::*;
#(
  parameter int W          = EM_PAYLOAD_W,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         drop,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] r_q;
  logic         r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      r_valid <= 1'b0;
      if (CLEAR_DATA) begin
        r_q <= {W{BUBBLE_FILL}};
      end
    end else if (load) begin
      r_q     <= d;
      r_valid <= 1'b1;
    end else if (drop) begin
      r_valid <= 1'b0;
    end
  end

  assign q     = r_q;
  assign valid = r_valid;

endmodule : pipe_stage_hs_slot
`default_nettype wire

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs
// Purpose  : Generic pipeline-stage register with a valid/ready handshake,
//            an optional 2-entry skid buffer, a synchronous flush and a
//            saturating stall counter.
// Ports    : clk        rising-edge clock
//            reset      asynchronous, active-low
//            flush      synchronous kill of all held entries
//            up         slave channel  (in_valid / in_ready / in_data)
//            dn         master channel (out_valid / out_ready / out_data)
//            occupancy  entries held (0..2)
//            stall_cnt  saturating count of cycles with out_valid & !out_ready
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int PAYLOAD_W      = EM_PAYLOAD_W,
  parameter bit SKID           = 1'b1,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_hs_if.slave   up,
  pipe_stage_hs_if.master  dn,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [PAYLOAD_W-1:0] w_in_data;
  logic [PAYLOAD_W-1:0] w_main_d;
  logic [PAYLOAD_W-1:0] w_main_q;
  logic                 w_in_valid;
  logic                 w_out_ready;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_main_load;
  logic                 w_main_drop;
  logic                 w_main_valid;
  logic [1:0]           w_occupancy;
  logic [CNT_W-1:0]     r_stall_cnt;

  assign w_in_data   = up.data;
  assign w_in_valid  = up.valid;
  assign w_out_ready = dn.ready;
  assign w_in_fire   = w_in_valid & w_in_ready;
  assign w_out_fire  = w_main_valid & w_out_ready;

  // The output always comes from the main entry.
  pipe_stage_hs_slot #(
    .W          (PAYLOAD_W),
    .CLEAR_DATA (CLEAR_ON_FLUSH)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (w_main_load),
    .drop  (w_main_drop),
    .clear (flush),
    .d     (w_main_d),
    .q     (w_main_q),
    .valid (w_main_valid)
  );

  if (SKID) begin : g_skid
    occ_state_e           r_state;
    occ_state_e           w_state_nxt;
    logic                 r_in_ready;
    logic                 w_skid_load;
    logic                 w_skid_drop;
    logic                 w_skid_valid;
    logic [PAYLOAD_W-1:0] w_skid_q;

    pipe_stage_hs_slot #(
      .W          (PAYLOAD_W),
      .CLEAR_DATA (CLEAR_ON_FLUSH)
    ) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (w_skid_load),
      .drop  (w_skid_drop),
      .clear (flush),
      .d     (w_in_data),
      .q     (w_skid_q),
      .valid (w_skid_valid)
    );

    // in_ready is registered from the next state so that the upstream
    // ready path carries no combinational dependency on out_ready.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_state_nxt;
        r_in_ready <= (w_state_nxt != ST_FULL);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_main_load = 1'b0;
      w_main_drop = 1'b0;
      w_skid_load = 1'b0;
      w_skid_drop = 1'b0;
      w_main_d    = w_in_data;
      // A flush wins; a same-cycle in_fire is accepted and thrown away.
      if (flush) begin
        w_state_nxt = ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              w_main_load = 1'b1;
              w_state_nxt = ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
              w_main_load = 1'b1;
            end else if (w_in_fire) begin
              w_skid_load = 1'b1;
              w_state_nxt = ST_FULL;
            end else if (w_out_fire) begin
              w_main_drop = 1'b1;
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_FULL: begin
            // in_ready is low here, so only the skid entry can advance.
            if (w_out_fire) begin
              w_main_d    = w_skid_q;
              w_main_load = 1'b1;
              w_skid_drop = 1'b1;
              w_state_nxt = ST_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
      end
    end

    assign w_in_ready  = r_in_ready;
    assign w_occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
  end else begin : g_noskid
    // Single entry: it can accept whenever it is empty or draining this cycle.
    assign w_in_ready = ~w_main_valid | w_out_ready;

    always_comb begin
      w_main_d    = w_in_data;
      w_main_load = w_in_fire & ~flush;
      w_main_drop = w_out_fire & ~w_in_fire;
    end

    assign w_occupancy = {1'b0, w_main_valid};
  end

  // Saturating stall counter; flush leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !w_out_ready && (r_stall_cnt != C_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
    end
  end

  assign up.ready  = w_in_ready;
  assign dn.valid  = w_main_valid;
  assign dn.data   = w_main_q;
  assign occupancy = w_occupancy;
  assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_hs
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_hs
// Purpose  : Self-checking bench for pipe_stage_hs. Two instances run side by
//            side: index 0 uses SKID=1 with CNT_W=4, and index 1 uses SKID=0
//            with CNT_W=16. A queue-based reference model tracks the random
//            traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;
  import pipe_stage_hs_pkg::*;

  localparam int PW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid  [2];
  logic [PW-1:0] in_data   [2];
  logic          out_ready [2];
  logic          flush     [2];
  logic          in_ready_o  [2];
  logic          out_valid_o [2];
  logic [PW-1:0] out_data_o  [2];
  logic [1:0]    occ_o       [2];
  logic [15:0]   stall_o     [2];
  logic [1:0]    occ0, occ1;
  logic [3:0]    st0;
  logic [15:0]   st1;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_stage_hs_if #(.W(PW)) up0 ();
  pipe_stage_hs_if #(.W(PW)) dn0 ();
  pipe_stage_hs_if #(.W(PW)) up1 ();
  pipe_stage_hs_if #(.W(PW)) dn1 ();

  pipe_stage_hs #(.PAYLOAD_W(PW), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .flush(flush[0]), .up(up0), .dn(dn0),
    .occupancy(occ0), .stall_cnt(st0)
  );
  pipe_stage_hs #(.PAYLOAD_W(PW), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .flush(flush[1]), .up(up1), .dn(dn1),
    .occupancy(occ1), .stall_cnt(st1)
  );

  assign up0.valid = in_valid[0];
  assign up0.data  = in_data[0];
  assign dn0.ready = out_ready[0];
  assign up1.valid = in_valid[1];
  assign up1.data  = in_data[1];
  assign dn1.ready = out_ready[1];
  assign in_ready_o[0]  = up0.ready;
  assign in_ready_o[1]  = up1.ready;
  assign out_valid_o[0] = dn0.valid;
  assign out_valid_o[1] = dn1.valid;
  assign out_data_o[0]  = dn0.data;
  assign out_data_o[1]  = dn1.data;
  assign occ_o[0]       = occ0;
  assign occ_o[1]       = occ1;
  assign stall_o[0]     = {12'd0, st0};
  assign stall_o[1]     = st1;

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0; flush[d] = 1'b0;
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Fresh reset values, then a reset asserted asynchronously mid-stream.
  task automatic test_reset();
    do_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (in_ready_o[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d] got %b want 1", d, in_ready_o[d]); end
      n_cmp++; if (out_valid_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d] got %b want 0", d, out_valid_o[d]); end
      n_cmp++; if (occ_o[d] !== 2'd0) begin n_fail++; $display("FAIL reset_occ[%0d] got %0d want 0", d, occ_o[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin in_valid[d] = 1'b1; in_data[d] = 32'hABCD_0000 + d; end
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (out_valid_o[d] !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid[%0d] got %b want 0", d, out_valid_o[d]); end
      n_cmp++; if (out_data_o[d] !== '0) begin n_fail++; $display("FAIL midrst_out_data[%0d] got %h want 0", d, out_data_o[d]); end
      n_cmp++; if (occ_o[d] !== 2'd0) begin n_fail++; $display("FAIL midrst_occ[%0d] got %0d want 0", d, occ_o[d]); end
      n_cmp++; if (stall_o[d] !== 16'd0) begin n_fail++; $display("FAIL midrst_stall[%0d] got %0d want 0", d, stall_o[d]); end
      in_valid[d] = 1'b0;
    end
    reset = 1'b1;
  endtask

  // 1..8 streamed with out_ready=1: 1-cycle latency, no gaps, in_ready high.
  task automatic test_stream();
    do_reset();
    for (int d = 0; d < 2; d++) out_ready[d] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (k > 1) begin
          n_cmp++; if (out_valid_o[d] !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] k=%0d got %b want 1", d, k, out_valid_o[d]); end
          n_cmp++; if (out_data_o[d] !== PW'(k - 1)) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", d, out_data_o[d], k - 1); end
        end
        in_valid[d] = (k <= 8);
        in_data[d]  = PW'(k);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        if (k <= 8) begin
          n_cmp++; if (in_ready_o[d] !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] k=%0d got %b want 1", d, k, in_ready_o[d]); end
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (out_valid_o[d] !== 1'b0) begin n_fail++; $display("FAIL stream_drain[%0d] got %b want 0", d, out_valid_o[d]); end
    end
  endtask

  // Skid instance: A, B accepted while blocked, then drained in order.
  task automatic test_skid_full();
    do_reset();
    @(negedge clk); in_valid[0] = 1'b1; in_data[0] = 32'hAAAA_0001; out_ready[0] = 1'b0;
    @(negedge clk); in_data[0] = 32'hBBBB_0002;
    #1;
    n_cmp++; if (in_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL skid_ready_one got %b want 1", in_ready_o[0]); end
    @(negedge clk); in_valid[0] = 1'b0;
    #1;
    n_cmp++; if (occ_o[0] !== 2'd2) begin n_fail++; $display("FAIL skid_occ_full got %0d want 2", occ_o[0]); end
    n_cmp++; if (in_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL skid_ready_full got %b want 0", in_ready_o[0]); end
    n_cmp++; if (out_data_o[0] !== 32'hAAAA_0001) begin n_fail++; $display("FAIL skid_head got %h want AAAA0001", out_data_o[0]); end
    repeat (3) @(negedge clk);
    out_ready[0] = 1'b1;
    #1;
    n_cmp++; if (out_data_o[0] !== 32'hAAAA_0001) begin n_fail++; $display("FAIL skid_out_a got %h want AAAA0001", out_data_o[0]); end
    @(negedge clk);
    n_cmp++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== 32'hBBBB_0002) begin n_fail++; $display("FAIL skid_out_b got v=%b %h want v=1 BBBB0002", out_valid_o[0], out_data_o[0]); end
    n_cmp++; if (in_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL skid_ready_after got %b want 1", in_ready_o[0]); end
    @(negedge clk);
    n_cmp++; if (out_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL skid_empty got %b want 0", out_valid_o[0]); end
    n_cmp++; if (stall_o[0] !== 16'd4) begin n_fail++; $display("FAIL skid_stall got %0d want 4", stall_o[0]); end
  endtask

  // Flush from FULL (C blocked) and from ONE (C accepted): C must never appear.
  task automatic test_flush();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      @(negedge clk); in_valid[0] = 1'b1; in_data[0] = 32'hAAAA_0001;
      if (pass == 0) begin @(negedge clk); in_data[0] = 32'hBBBB_0002; end
      @(negedge clk); in_data[0] = 32'hC0FF_EE00; flush[0] = 1'b1;
      @(negedge clk); in_valid[0] = 1'b0; flush[0] = 1'b0; out_ready[0] = 1'b1;
      #1;
      n_cmp++; if (out_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL flush_valid[p%0d] got %b want 0", pass, out_valid_o[0]); end
      n_cmp++; if (out_data_o[0] !== '0) begin n_fail++; $display("FAIL flush_data[p%0d] got %h want 0", pass, out_data_o[0]); end
      n_cmp++; if (in_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL flush_ready[p%0d] got %b want 1", pass, in_ready_o[0]); end
      n_cmp++; if (occ_o[0] !== 2'd0) begin n_fail++; $display("FAIL flush_occ[p%0d] got %0d want 0", pass, occ_o[0]); end
      repeat (3) begin
        @(negedge clk);
        n_cmp++; if (out_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[p%0d] got %b data %h want 0", pass, out_valid_o[0], out_data_o[0]); end
      end
    end
  endtask

  // CNT_W=4 instance held 20 cycles: counter stops at 15, output frozen.
  task automatic test_stall_sat();
    do_reset();
    @(negedge clk); in_valid[0] = 1'b1; in_data[0] = 32'hEEEE_0005;
    @(negedge clk); in_valid[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 9) begin
        n_cmp++; if (stall_o[0] !== 16'd10) begin n_fail++; $display("FAIL sat_mid got %0d want 10", stall_o[0]); end
      end
    end
    n_cmp++; if (stall_o[0] !== 16'd15) begin n_fail++; $display("FAIL sat_end got %0d want 15", stall_o[0]); end
    n_cmp++; if (out_valid_o[0] !== 1'b1 || out_data_o[0] !== 32'hEEEE_0005) begin n_fail++; $display("FAIL sat_hold got v=%b %h want v=1 EEEE0005", out_valid_o[0], out_data_o[0]); end
  endtask

  // Non-skid instance: in_ready follows out_ready and the stage refills without a bubble.
  task automatic test_noskid();
    do_reset();
    @(negedge clk); in_valid[1] = 1'b1; in_data[1] = 32'h1111_0001; out_ready[1] = 1'b0;
    @(negedge clk); in_valid[1] = 1'b0;
    #1;
    n_cmp++; if (in_ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL nsk_blocked got %b want 0", in_ready_o[1]); end
    @(negedge clk); out_ready[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 32'hD0D0_0D0D;
    #1;
    n_cmp++; if (in_ready_o[1] !== 1'b1) begin n_fail++; $display("FAIL nsk_ready got %b want 1", in_ready_o[1]); end
    n_cmp++; if (out_data_o[1] !== 32'h1111_0001) begin n_fail++; $display("FAIL nsk_first got %h want 11110001", out_data_o[1]); end
    @(negedge clk); in_valid[1] = 1'b0;
    #1;
    n_cmp++; if (out_valid_o[1] !== 1'b1 || out_data_o[1] !== 32'hD0D0_0D0D) begin n_fail++; $display("FAIL nsk_nobubble got v=%b %h want v=1 D0D00D0D", out_valid_o[1], out_data_o[1]); end
    @(negedge clk);
    n_cmp++; if (out_valid_o[1] !== 1'b0) begin n_fail++; $display("FAIL nsk_drain got %b want 0", out_valid_o[1]); end
  endtask

  // Random traffic against a FIFO model of capacity 2 (skid) or 1 (no skid).
  task automatic test_random(input int d, input int n);
    logic [PW-1:0] q[$];
    int  cnt;
    int  cmax;
    bit  hold;
    bit  exp_rdy, in_fire, out_fire, stall;
    cnt  = 0;
    cmax = (d == 0) ? 15 : 65535;
    hold = 1'b0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid[d] = ($urandom_range(0, 3) != 0);
        in_data[d]  = $urandom;
      end
      out_ready[d] = ($urandom_range(0, 2) != 0);
      flush[d]     = ($urandom_range(0, 19) == 0);
      #1;
      exp_rdy = (d == 0) ? (q.size() < 2) : (q.size() == 0 || out_ready[d]);
      n_cmp++; if (in_ready_o[d] !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready[%0d] c=%0d got %b want %b", d, c, in_ready_o[d], exp_rdy); end
      n_cmp++; if (out_valid_o[d] !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid[%0d] c=%0d got %b want %b", d, c, out_valid_o[d], q.size() > 0); end
      if (q.size() > 0) begin
        n_cmp++; if (out_data_o[d] !== q[0]) begin n_fail++; $display("FAIL rnd_out_data[%0d] c=%0d got %h want %h", d, c, out_data_o[d], q[0]); end
      end
      n_cmp++; if (occ_o[d] !== 2'(q.size())) begin n_fail++; $display("FAIL rnd_occ[%0d] c=%0d got %0d want %0d", d, c, occ_o[d], q.size()); end
      n_cmp++; if (stall_o[d] !== 16'(cnt)) begin n_fail++; $display("FAIL rnd_stall[%0d] c=%0d got %0d want %0d", d, c, stall_o[d], cnt); end
      in_fire  = in_valid[d] && exp_rdy;
      out_fire = (q.size() > 0) && out_ready[d];
      stall    = (q.size() > 0) && !out_ready[d];
      hold     = in_valid[d] && !exp_rdy;
      @(posedge clk);
      if (stall && cnt < cmax) cnt++;
      if (flush[d]) q.delete();
      else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) q.push_back(in_data[d]);
      end
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b0; flush[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_skid_full();
    test_flush();
    test_stall_sat();
    test_noskid();
    test_random(0, 600);
    test_random(1, 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_hs
`default_nettype wire
